mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles a grant waits for m_ready.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_a in 32 and i_strobe in 1: instruction-cache miss address and read request.
REQ-005 SHALL have ports i_dout out 32 and i_ready out 1: read data and completion to the instruction cache.
REQ-006 SHALL have ports d_a in 32, d_strobe in 1, d_rw in 1 (1 = write) and d_din in 32: data-cache request.
REQ-007 SHALL have ports d_dout out 32 and d_ready out 1: read data and completion to the data cache.
REQ-008 SHALL have ports m_a out 32, m_strobe out 1, m_rw out 1, m_din out 32, m_dout in 32 and m_ready in 1: the shared memory port.
REQ-009 SHALL have port m_err out 1: sticky memory-timeout flag.

Function
REQ-010 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-011 In IDLE, no strobe: SHALL remain in IDLE.
REQ-012 In IDLE, only i_strobe=1: SHALL go to GNT_I next cycle.
REQ-013 In IDLE, only d_strobe=1: SHALL go to GNT_D next cycle.
REQ-014 In IDLE, both strobes=1: SHALL choose per REQ-030/031.
REQ-015 In GNT_x: m_strobe=1; m_a, m_rw, m_din combinationally from requester x; m_rw=0 in GNT_I.
REQ-016 In IDLE: m_strobe=0, m_rw=0, m_a=0, m_din=0.
REQ-017 In GNT_x with m_ready=1: SHALL assert x_ready=1 in that same cycle, drive x_dout=m_dout and return to IDLE.
REQ-018 The non-granted requester's ready SHALL be 0.
REQ-019 i_dout/d_dout SHALL be 0 whenever the matching ready is 0.
REQ-020 Minimum latency from strobe to ready SHALL be 2 cycles: arbitration cycle, then first GNT cycle with m_ready=1.
REQ-021 Back-to-back grants SHALL always be separated by one IDLE cycle.
REQ-022 If the granted requester drops its strobe while in GNT_x, the arbiter SHALL go to IDLE without asserting ready.
REQ-023 A wait counter SHALL clear on grant entry and increment each GNT cycle with m_ready=0.
REQ-024 At count TIMEOUT the arbiter SHALL set m_err=1, return to IDLE without ready, and re-arbitrate normally.
REQ-025 m_err SHALL stay 1 until reset.
REQ-026 The wait counter SHALL be 8 bits wide, SHALL saturate and SHALL never wrap.
REQ-027 Strobe changes of the non-granted requester during a grant SHALL be ignored until IDLE.

Reset
REQ-028 With rst=1 at a rising clk edge: state=IDLE, counter=0, m_err=0, last-served flag=I.
REQ-029 All outputs SHALL take their IDLE values in the cycle after reset, including reset asserted mid-grant; no ready pulse SHALL be issued for the aborted transfer.

Configuration
REQ-030 With macro MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL grant the requester not served last; the last-served flag updates on every grant.
REQ-031 Without MEM_ARB_RR_EN, simultaneous requests SHALL always grant D; no last-served flag is built.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold the FSM state encodings (IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2) and the default TIMEOUT constant.
REQ-033 The wait counter and its timeout compare SHALL be a sub-module, mem_arb_timer.

Verification
REQ-034 i_strobe=1, i_a=32'h0000_0100; m_ready=1 from the 2nd cycle, m_dout=32'hDEAD_BEEF -> m_a=32'h100, m_strobe=1, m_rw=0; i_ready=1 with i_dout=32'hDEAD_BEEF in the 2nd cycle.
REQ-035 d_strobe=1, d_rw=1, d_a=32'h200, d_din=32'h1234_5678; m_ready=1 after 3 wait cycles -> m_rw=1, m_din=32'h1234_5678; d_ready=1 on the 5th cycle.
REQ-036 Both strobes high in IDLE, m_ready=1 every GNT cycle -> without macro: D, D, D...; with MEM_ARB_RR_EN: D, I, D, I..., each grant followed by one IDLE cycle.
REQ-037 TIMEOUT=4, i_strobe=1, m_ready=0 held -> m_err=1 after 4 GNT cycles, state IDLE, i_ready never 1; m_err stays 1 for all later cycles.
REQ-038 rst=1 during GNT_D with m_ready=0 -> next cycle m_strobe=0, d_ready=0, m_err=0; after reset release with d_strobe=1 -> GNT_D re-entered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared constants for the instruction/data memory arbiter:
//               FSM state encodings, wait-counter width and default timeout.
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GNT_I = 2'd1;
    localparam logic [1:0] c_GNT_D = 2'd2;

    // Default number of cycles a grant may wait for m_ready
    localparam int c_TIMEOUT_DEFAULT = 255;

    // Wait counter geometry
    localparam int                 c_CNT_W   = 8;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_timer
// Description : Saturating 8-bit wait counter for the memory arbiter. Clears
//               when a grant starts, counts each stalled grant cycle and flags
//               a timeout on the stalled cycle that reaches TIMEOUT.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic wait_i,
    output logic timeout_o
);

    localparam logic [31:0] c_LIMIT = 32'(TIMEOUT);

    logic [c_CNT_W-1:0] r_count_q;
    logic [c_CNT_W-1:0] w_count_d;
    logic [31:0]        w_count_next_ext;

    // Next count: clear on grant entry, otherwise count stalls without wrapping
    always_comb begin
        w_count_d = r_count_q;
        if (clear_i) begin
            w_count_d = '0;
        end else if (wait_i && (r_count_q != c_CNT_MAX)) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    // The stall in progress is number count+1; it times out when that reaches the limit
    assign w_count_next_ext = {{(32-c_CNT_W){1'b0}}, r_count_q} + 32'd1;
    assign timeout_o        = wait_i && (w_count_next_ext >= c_LIMIT);

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule : mem_arb_timer
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (I-cache / D-cache) arbiter onto one memory
//               port. IDLE arbitrates, GNT_x forwards requester x to memory
//               until m_ready, strobe drop or timeout, then returns to IDLE.
//               Optional macro MEM_ARB_RR_EN: round-robin on simultaneous
//               requests; otherwise D always wins a tie.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    // instruction cache
    input  logic [31:0] i_a,
    input  logic        i_strobe,
    output logic [31:0] i_dout,
    output logic        i_ready,
    // data cache
    input  logic [31:0] d_a,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [31:0] d_din,
    output logic [31:0] d_dout,
    output logic        d_ready,
    // shared memory port
    output logic [31:0] m_a,
    output logic        m_strobe,
    output logic        m_rw,
    output logic [31:0] m_din,
    input  logic [31:0] m_dout,
    input  logic        m_ready,
    output logic        m_err
);

    logic [1:0] r_state_q;
    logic [1:0] w_state_d;
    logic       r_err_q;
    logic       w_err_d;
    logic       w_gnt_i;
    logic       w_gnt_d;
    logic       w_owner_live;
    logic       w_wait;
    logic       w_timeout;
    logic       w_entry;
    logic       w_pick_d;

    assign w_gnt_i      = (r_state_q == c_GNT_I);
    assign w_gnt_d      = (r_state_q == c_GNT_D);
    // Only the granted requester's strobe matters during a grant
    assign w_owner_live = (w_gnt_i && i_strobe) || (w_gnt_d && d_strobe);
    assign w_wait       = w_owner_live && !m_ready;
    assign w_entry      = (r_state_q == c_IDLE) && (i_strobe || d_strobe);

`ifdef MEM_ARB_RR_EN
    logic r_last_d_q;
    logic w_last_d_d;

    // On a tie grant whichever side was not served last
    assign w_pick_d   = d_strobe && (!i_strobe || !r_last_d_q);
    assign w_last_d_d = w_entry ? w_pick_d : r_last_d_q;

    // Last-served flag, reset to "I served last" so the first tie goes to D
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d_q <= 1'b0;
        end else begin
            r_last_d_q <= w_last_d_d;
        end
    end
`else
    // Fixed priority: D wins every tie
    assign w_pick_d = d_strobe;
`endif

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_entry),
        .wait_i    (w_wait),
        .timeout_o (w_timeout)
    );

    // Next-state logic: arbitrate in IDLE, leave a grant on done/drop/timeout
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE: begin
                if (i_strobe || d_strobe) begin
                    w_state_d = w_pick_d ? c_GNT_D : c_GNT_I;
                end
            end
            c_GNT_I, c_GNT_D: begin
                if (!w_owner_live || m_ready || w_timeout) begin
                    w_state_d = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
    end

    assign w_err_d = r_err_q || w_timeout;

    // State and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_IDLE;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_err_q   <= w_err_d;
        end
    end

    // Memory port mux: granted requester drives memory, IDLE drives zeros
    always_comb begin
        m_strobe = 1'b0;
        m_rw     = 1'b0;
        m_a      = 32'd0;
        m_din    = 32'd0;
        case (r_state_q)
            c_GNT_I: begin
                m_strobe = 1'b1;
                m_a      = i_a;
            end
            c_GNT_D: begin
                m_strobe = 1'b1;
                m_a      = d_a;
                m_rw     = d_rw;
                m_din    = d_din;
            end
            default: ;
        endcase
    end

    // Completion is same-cycle with m_ready; suppressed while reset aborts a transfer
    assign i_ready = w_gnt_i && i_strobe && m_ready && !rst;
    assign d_ready = w_gnt_d && d_strobe && m_ready && !rst;
    assign i_dout  = i_ready ? m_dout : 32'd0;
    assign d_dout  = d_ready ? m_dout : 32'd0;
    assign m_err   = r_err_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. A transaction-level model
//               predicts every cycle's port values and each completion; a
//               separate monitor pops and compares against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_TO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit c_RR = 1'b1;
`else
    localparam bit c_RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_a = '0;
    logic        i_strobe = 1'b0;
    logic [31:0] i_dout;
    logic        i_ready;
    logic [31:0] d_a = '0;
    logic        d_strobe = 1'b0;
    logic        d_rw = 1'b0;
    logic [31:0] d_din = '0;
    logic [31:0] d_dout;
    logic        d_ready;
    logic [31:0] m_a;
    logic        m_strobe;
    logic        m_rw;
    logic [31:0] m_din;
    logic [31:0] m_dout = '0;
    logic        m_ready = 1'b0;
    logic        m_err;

    mem_arbiter #(.TIMEOUT(c_TO)) dut (
        .clk(clk), .rst(rst),
        .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
        .d_a(d_a), .d_strobe(d_strobe), .d_rw(d_rw), .d_din(d_din),
        .d_dout(d_dout), .d_ready(d_ready),
        .m_a(m_a), .m_strobe(m_strobe), .m_rw(m_rw), .m_din(m_din),
        .m_dout(m_dout), .m_ready(m_ready), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m_a, m_din, i_dout, d_dout;
        logic        m_strobe, m_rw, i_ready, d_ready, m_err;
    } port_t;

    typedef struct {
        bit          to_d;
        logic [31:0] data;
    } done_t;

    port_t port_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_done_exp = 0;
    int n_done_seen = 0;

    // Reference model: who owns the memory (0 none, 1 I, 2 D), stalls so far,
    // sticky error, and who was served last (1 I, 2 D)
    int owner  = 0;
    int waited = 0;
    bit err    = 1'b0;
    int last   = 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit is, input logic [31:0] ia,
                         input bit ds, input bit drw, input logic [31:0] da,
                         input logic [31:0] ddin, input bit mr,
                         input logic [31:0] mdo, input bit chk);
        port_t e;
        bit    live;
        bit    want_d;
        @(negedge clk);
        rst = r; i_strobe = is; i_a = ia; d_strobe = ds; d_rw = drw;
        d_a = da; d_din = ddin; m_ready = mr; m_dout = mdo;

        e = '{m_a: 32'd0, m_din: 32'd0, i_dout: 32'd0, d_dout: 32'd0,
              m_strobe: 1'b0, m_rw: 1'b0, i_ready: 1'b0, d_ready: 1'b0, m_err: err};
        if (owner == 1) begin
            e.m_strobe = 1'b1; e.m_a = ia;
        end else if (owner == 2) begin
            e.m_strobe = 1'b1; e.m_a = da; e.m_rw = drw; e.m_din = ddin;
        end

        if (r) begin
            owner = 0; waited = 0; err = 1'b0; last = 1;
        end else if (owner == 0) begin
            if (is || ds) begin
                if (is && ds) want_d = c_RR ? (last == 1) : 1'b1;
                else          want_d = ds;
                owner  = want_d ? 2 : 1;
                last   = owner;
                waited = 0;
            end
        end else begin
            live = (owner == 1) ? is : ds;
            if (!live) begin
                owner = 0;
            end else if (mr) begin
                if (owner == 1) begin e.i_ready = 1'b1; e.i_dout = mdo; end
                else            begin e.d_ready = 1'b1; e.d_dout = mdo; end
                if (chk) begin
                    done_q.push_back('{to_d: (owner == 2), data: mdo});
                    n_done_exp++;
                end
                owner = 0;
            end else begin
                waited++;
                if (waited >= c_TO) begin
                    err = 1'b1;
                    owner = 0;
                end
            end
        end
        if (chk) port_q.push_back(e);
    endtask

    // Monitor: compare every cycle's ports and every completion presented
    initial begin
        port_t e;
        done_t c;
        forever begin
            @(negedge clk);
            #2;
            if (port_q.size() > 0) begin
                e = port_q.pop_front();
                check("m_strobe", {31'd0, m_strobe}, {31'd0, e.m_strobe});
                check("m_a",      m_a,               e.m_a);
                check("m_rw",     {31'd0, m_rw},     {31'd0, e.m_rw});
                check("m_din",    m_din,             e.m_din);
                check("m_err",    {31'd0, m_err},    {31'd0, e.m_err});
                check("i_ready",  {31'd0, i_ready},  {31'd0, e.i_ready});
                check("d_ready",  {31'd0, d_ready},  {31'd0, e.d_ready});
                check("i_dout",   i_dout,            e.i_dout);
                check("d_dout",   d_dout,            e.d_dout);
            end
            if (i_ready === 1'b1 || d_ready === 1'b1) begin
                n_done_seen++;
                check("single_ready", {31'd0, (i_ready & d_ready)}, 32'd0);
                if (done_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_ready at %0t: got ready with data %h expected none",
                             $time, i_ready ? i_dout : d_dout);
                end else begin
                    c = done_q.pop_front();
                    check("done_to_d", {31'd0, d_ready}, {31'd0, c.to_d});
                    check("done_data", d_ready ? d_dout : i_dout, c.data);
                end
            end
        end
    end

    initial begin
        // Reset: first cycle unchecked (state unknown), second fully checked
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // I-cache read, memory ready on the first grant cycle
        repeat (2) drive(0, 1, 32'h100, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // D-cache write with three stall cycles
        repeat (4) drive(0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 0, 32'h0, 1);
        drive(0, 0, 0, 1, 1, 32'h200, 32'h1234_5678, 1, 32'h5A5A_0001, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Both requesters permanently asking, memory always ready
        for (int k = 0; k < 8; k++)
            drive(0, 1, 32'h300 + k, 1, 0, 32'h400 + k, 32'h0, 1, 32'hC000_0000 + k, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Timeout: I-cache read that memory never answers
        repeat (7) drive(0, 1, 32'h500, 0, 0, 0, 0, 0, 32'h0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of a stalled D grant, then the grant resumes
        repeat (3) drive(0, 0, 0, 1, 0, 32'h600, 32'h0, 0, 32'h0, 1);
        drive(1, 0, 0, 1, 0, 32'h600, 32'h0, 1, 32'h77, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 32'h600, 32'h0, 0, 32'h0, 1);
        drive(0, 0, 0, 1, 0, 32'h600, 32'h0, 1, 32'h88, 1);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++)
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom,
                  $urandom, $urandom_range(0, 2) == 0, $urandom, 1);

        repeat (3) @(negedge clk);
        check("port_q_drained", port_q.size(), 32'd0);
        check("done_q_drained", done_q.size(), 32'd0);
        check("done_count", n_done_seen, n_done_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
